// File: rtl/bin_sub_serial_if.sv
// bin_sub_serial_if: start/operand/result bundle for the bit-serial subtractor; ovf_o exists only with SUB_SIGNED_OVF_EN
interface bin_sub_serial_if #(parameter int N = 4);
    logic         start_i;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] d_o;
    logic         bout_o;
`ifdef SUB_SIGNED_OVF_EN
    logic         ovf_o;
`endif
    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, d_o, bout_o
`ifdef SUB_SIGNED_OVF_EN
        , ovf_o
`endif
    );
    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, d_o, bout_o
`ifdef SUB_SIGNED_OVF_EN
        , ovf_o
`endif
    );
endinterface

// File: rtl/bin_sub_serial.sv
// bin_sub_serial: LSB-first bit-serial N-bit subtractor with borrow flop; SUB_SIGNED_OVF_EN adds registered signed overflow
module bin_sub_serial #(parameter int N = 4) (
    input logic             clk,
    input logic             rst,
    bin_sub_serial_if.slave bus
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, d_q, d_d;
    logic [N-2:0]  r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          br_q, br_d, bout_q, bout_d;
    logic          diff, br_nx;
`ifdef SUB_SIGNED_OVF_EN
    logic          ovf_q, ovf_d;
    assign bus.ovf_o = ovf_q;
`endif
    assign bus.busy_o = state_q == SHIFT;
    assign bus.done_o = state_q == DONE;
    assign bus.d_o    = d_q;
    assign bus.bout_o = bout_q;
    // state and datapath registers; reset wins over everything, aborting any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
`ifdef SUB_SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end
    // next state: operands shift right so bit 0 is always the current bit; partial result fills from the top
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        d_d     = d_q;
        bout_d  = bout_q;
        diff    = a_q[0] ^ b_q[0] ^ br_q;
        br_nx   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
`ifdef SUB_SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (bus.start_i) begin
                a_d     = bus.a_i;
                b_d     = bus.b_i;
                br_d    = 1'b0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = (N-1)'({diff, r_q} >> 1);
                br_d  = br_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N-1)) begin
                    d_d     = {diff, r_q};
                    bout_d  = br_nx;
                    state_d = DONE;
`ifdef SUB_SIGNED_OVF_EN
                    ovf_d   = (a_q[0] != b_q[0]) && (diff != a_q[0]);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
